// File: rtl/acc_ctrl_16bit_pkg.sv
`default_nettype none
// ============================================================================
// acc_ctrl_16bit_pkg
// Shared encodings for the accumulator/flag stage: ops, FSM states, flag bits.
// Revision: 1.0
// ============================================================================
package acc_ctrl_16bit_pkg;

  localparam int DEF_WIDTH = 16;

  typedef logic [1:0] op_t;

  localparam op_t OP_LOAD = 2'b00;
  localparam op_t OP_ADD  = 2'b01;
  localparam op_t OP_SUB  = 2'b10;
  localparam op_t OP_CMP  = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage
`default_nettype wire

// File: rtl/acc_ctrl_16bit_if.sv
`default_nettype none
// ============================================================================
// acc_ctrl_16bit_if
// Command handshake, add/sub unit connection and result bundle of the stage.
// Revision: 1.0
// ============================================================================
interface acc_ctrl_16bit_if #(
  parameter int WIDTH = 16
);
  logic             iValid;
  logic             oReady;
  logic [1:0]       iOp;
  logic [WIDTH-1:0] iData;
  logic [WIDTH-1:0] oAddA;
  logic [WIDTH-1:0] oAddB;
  logic             oAddSel;
  logic [WIDTH-1:0] iAddS;
  logic             iAddC;
  logic [WIDTH-1:0] oAcc;
  logic [3:0]       oFlags;
  logic             oDone;

  modport slave (
    input  iValid, iOp, iData, iAddS, iAddC,
    output oReady, oAddA, oAddB, oAddSel, oAcc, oFlags, oDone
  );

  modport master (
    output iValid, iOp, iData, iAddS, iAddC,
    input  oReady, oAddA, oAddB, oAddSel, oAcc, oFlags, oDone
  );
endinterface
`default_nettype wire

// File: rtl/acc_ctrl_16bit_flag_gen.sv
`default_nettype none
// ============================================================================
// acc_flag_gen
// Combinational Z/N/C/V generation from adder operands, sum, carry and op.
// Revision: 1.0
// ============================================================================
module acc_flag_gen
  import acc_ctrl_16bit_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] s,
  input  logic             carry,
  input  op_t              op,
  output logic [3:0]       flags
);

  logic a_msb, b_msb, s_msb;

  assign a_msb = a[WIDTH-1];
  assign b_msb = b[WIDTH-1];
  assign s_msb = s[WIDTH-1];

  always_comb begin
    flags         = '0;
    flags[FLAG_Z] = (s == '0);
    flags[FLAG_N] = s_msb;
    case (op)
      OP_ADD: begin
        flags[FLAG_C] = carry;
        flags[FLAG_V] = (a_msb == b_msb) && (s_msb != a_msb);
      end
      OP_SUB, OP_CMP: begin
        // carry=1 means no borrow under the A + ~B + 1 convention
        flags[FLAG_C] = carry;
        flags[FLAG_V] = (a_msb != b_msb) && (s_msb != a_msb);
      end
      default: begin
        flags[FLAG_C] = 1'b0;
        flags[FLAG_V] = 1'b0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/acc_ctrl_16bit.sv
`default_nettype none
// ============================================================================
// acc_ctrl_16bit
// Accumulator/flag stage driving an external combinational add/sub unit.
// Revision: 1.0
// ============================================================================
module acc_ctrl_16bit
  import acc_ctrl_16bit_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic        iClk,
  input  logic        iRstn,
  acc_ctrl_16bit_if.slave bus
);

  logic [1:0]       state_q, state_d;
  op_t              op_q, op_d;
  logic [WIDTH-1:0] add_a_q, add_a_d;
  logic [WIDTH-1:0] add_b_q, add_b_d;
  logic             add_sel_q, add_sel_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [3:0]       flags_q, flags_d;
  logic             done_q, done_d;
  logic [3:0]       flags_new;

  acc_flag_gen #(.WIDTH(WIDTH)) u_flag_gen (
    .a     (add_a_q),
    .b     (add_b_q),
    .s     (bus.iAddS),
    .carry (bus.iAddC),
    .op    (op_q),
    .flags (flags_new)
  );

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    add_a_d   = add_a_q;
    add_b_d   = add_b_q;
    add_sel_d = add_sel_q;
    acc_d     = acc_q;
    flags_d   = flags_q;
    done_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Adder operands are registered here so EXEC sees no path from iData
        if (bus.iValid) begin
          op_d      = bus.iOp;
          add_a_d   = (bus.iOp == OP_LOAD) ? '0 : acc_q;
          add_b_d   = bus.iData;
          add_sel_d = (bus.iOp == OP_SUB) || (bus.iOp == OP_CMP);
          state_d   = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (op_q != OP_CMP) begin
          acc_d = bus.iAddS;
        end
        flags_d = flags_new;
        done_d  = 1'b1;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge iClk or negedge iRstn) begin
    if (!iRstn) begin
      state_q   <= ST_IDLE;
      op_q      <= OP_LOAD;
      add_a_q   <= '0;
      add_b_q   <= '0;
      add_sel_q <= 1'b0;
      acc_q     <= '0;
      flags_q   <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      add_a_q   <= add_a_d;
      add_b_q   <= add_b_d;
      add_sel_q <= add_sel_d;
      acc_q     <= acc_d;
      flags_q   <= flags_d;
      done_q    <= done_d;
    end
  end

  // Gated by the reset pin so the stage never advertises ready while held in reset
  assign bus.oReady  = iRstn && (state_q == ST_IDLE);
  assign bus.oAddA   = add_a_q;
  assign bus.oAddB   = add_b_q;
  assign bus.oAddSel = add_sel_q;
  assign bus.oAcc    = acc_q;
  assign bus.oFlags  = flags_q;
  assign bus.oDone   = done_q;

endmodule
`default_nettype wire

// File: tb/tb_acc_ctrl_16bit.sv
`default_nettype none
// ============================================================================
// tb_acc_ctrl_16bit
// Directed self-checking bench for acc_ctrl_16bit with a behavioural add/sub unit.
// Revision: 1.0
// ============================================================================
module tb_acc_ctrl_16bit;
  import acc_ctrl_16bit_pkg::*;

  logic iClk;
  logic iRstn;
  int   n_checks;
  int   n_pass;

  acc_ctrl_16bit_if #(.WIDTH(16)) bus ();

  acc_ctrl_16bit #(.WIDTH(16)) dut (
    .iClk  (iClk),
    .iRstn (iRstn),
    .bus   (bus.slave)
  );

  // External add/sub unit: S = A + B, or A + ~B + 1 when subtracting
  assign {bus.iAddC, bus.iAddS} = bus.oAddSel
      ? ({1'b0, bus.oAddA} + {1'b0, ~bus.oAddB} + 17'd1)
      : ({1'b0, bus.oAddA} + {1'b0, bus.oAddB});

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  // Issue one command from IDLE and check the 3-cycle handshake/oDone timing
  task automatic run_cmd(input op_t op, input logic [15:0] data, input string tag);
    int k;
    k = 0;
    while (!bus.oReady && k < 10) begin
      tick();
      k++;
    end
    check({tag, " ready_before"}, 32'(bus.oReady), 32'd1);
    bus.iValid = 1'b1;
    bus.iOp    = op;
    bus.iData  = data;
    tick();
    bus.iValid = 1'b0;
    bus.iData  = 16'hDEAD;
    check({tag, " exec_ready"}, 32'(bus.oReady), 32'd0);
    check({tag, " exec_done"},  32'(bus.oDone),  32'd0);
    tick();
    check({tag, " done_pulse"}, 32'(bus.oDone),  32'd1);
    check({tag, " done_ready"}, 32'(bus.oReady), 32'd0);
    tick();
    check({tag, " done_clear"}, 32'(bus.oDone),  32'd0);
    check({tag, " ready_after"}, 32'(bus.oReady), 32'd1);
  endtask

  task automatic check_res(input string tag, input logic [15:0] acc, input logic [3:0] flags);
    check({tag, " acc"},   32'(bus.oAcc),   32'(acc));
    check({tag, " flags"}, 32'(bus.oFlags), 32'(flags));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    n_checks   = 0;
    n_pass     = 0;
    iRstn      = 1'b0;
    bus.iValid = 1'b0;
    bus.iOp    = OP_LOAD;
    bus.iData  = '0;

    // Reset state
    tick();
    tick();
    check("rst ready", 32'(bus.oReady), 32'd0);
    check("rst acc",   32'(bus.oAcc),   32'd0);
    check("rst flags", 32'(bus.oFlags), 32'd0);
    check("rst done",  32'(bus.oDone),  32'd0);
    check("rst addA",  32'(bus.oAddA),  32'd0);
    check("rst addB",  32'(bus.oAddB),  32'd0);
    check("rst sel",   32'(bus.oAddSel), 32'd0);
    iRstn = 1'b1;
    tick();
    check("idle ready", 32'(bus.oReady), 32'd1);

    // 1: LOAD 5, ADD 3
    run_cmd(OP_LOAD, 16'd5, "load5");
    check_res("load5", 16'd5, 4'b0000);
    run_cmd(OP_ADD, 16'd3, "add3");
    check_res("add3", 16'd8, 4'b0000);

    // 2: subtraction with and without borrow
    run_cmd(OP_LOAD, 16'd109, "load109");
    run_cmd(OP_SUB, 16'd25, "sub25");
    check_res("sub25", 16'd84, 4'b0010);
    run_cmd(OP_LOAD, 16'd320, "load320");
    run_cmd(OP_SUB, 16'd347, "sub347");
    check_res("sub347", 16'hFFE5, 4'b0100);

    // 3: signed overflow and unsigned wrap
    run_cmd(OP_LOAD, 16'h7FFF, "load7fff");
    run_cmd(OP_ADD, 16'd1, "add_ovf");
    check_res("add_ovf", 16'h8000, 4'b0101);
    run_cmd(OP_LOAD, 16'hFFFF, "loadffff");
    run_cmd(OP_ADD, 16'd1, "add_wrap");
    check_res("add_wrap", 16'h0000, 4'b1010);

    // 4: CMP leaves the accumulator untouched
    run_cmd(OP_LOAD, 16'd898, "load898");
    run_cmd(OP_CMP, 16'd898, "cmp_eq");
    check_res("cmp_eq", 16'd898, 4'b1010);
    run_cmd(OP_CMP, 16'd1000, "cmp_lt");
    check_res("cmp_lt", 16'd898, 4'b0100);

    // 5: iValid held high with iData changing every cycle
    run_cmd(OP_LOAD, 16'd10, "load10");
    bus.iValid = 1'b1;
    bus.iOp    = OP_ADD;
    bus.iData  = 16'd1;
    tick();
    check("hold exec addA",  32'(bus.oAddA),  32'd10);
    check("hold exec addB",  32'(bus.oAddB),  32'd1);
    check("hold exec ready", 32'(bus.oReady), 32'd0);
    bus.iData = 16'd100;
    tick();
    check("hold done acc",  32'(bus.oAcc),  32'd11);
    check("hold done addB", 32'(bus.oAddB), 32'd1);
    check("hold done pulse", 32'(bus.oDone), 32'd1);
    bus.iData = 16'd200;
    tick();
    check("hold idle ready", 32'(bus.oReady), 32'd1);
    check("hold idle acc",   32'(bus.oAcc),   32'd11);
    bus.iData = 16'd2;
    tick();
    bus.iValid = 1'b0;
    check("hold 2nd addB", 32'(bus.oAddB),  32'd2);
    check("hold 2nd addA", 32'(bus.oAddA),  32'd11);
    tick();
    tick();
    check("hold 2nd acc",   32'(bus.oAcc),   32'd13);
    check("hold 2nd ready", 32'(bus.oReady), 32'd1);

    // 6: reset during EXEC aborts the command
    run_cmd(OP_LOAD, 16'd129, "load129");
    bus.iValid = 1'b1;
    bus.iOp    = OP_ADD;
    bus.iData  = 16'd500;
    tick();
    bus.iValid = 1'b0;
    check("abort exec addA", 32'(bus.oAddA), 32'd129);
    check("abort exec addB", 32'(bus.oAddB), 32'd500);
    iRstn = 1'b0;
    #1;
    check("abort acc",   32'(bus.oAcc),    32'd0);
    check("abort flags", 32'(bus.oFlags),  32'd0);
    check("abort done",  32'(bus.oDone),   32'd0);
    check("abort ready", 32'(bus.oReady),  32'd0);
    check("abort addA",  32'(bus.oAddA),   32'd0);
    check("abort addB",  32'(bus.oAddB),   32'd0);
    check("abort sel",   32'(bus.oAddSel), 32'd0);
    tick();
    check("abort hold done", 32'(bus.oDone), 32'd0);
    tick();
    check("abort hold acc", 32'(bus.oAcc), 32'd0);
    iRstn = 1'b1;
    tick();
    check("abort post ready", 32'(bus.oReady), 32'd1);
    check("abort post done",  32'(bus.oDone),  32'd0);
    check("abort post acc",   32'(bus.oAcc),   32'd0);
    run_cmd(OP_LOAD, 16'd7, "load7");
    check_res("load7", 16'd7, 4'b0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
